// File: rtl/por_seq_pkg.sv
// Shared types and constants for the power-on-reset sequencer.
package por_seq_pkg;

  // Sequencer states. Domain A is released in UP1. Domain B is released in UP2.
  typedef enum logic [2:0] {
    OFF  = 3'd0,
    DEB1 = 3'd1,
    DLY1 = 3'd2,
    UP1  = 3'd3,
    DEB2 = 3'd4,
    DLY2 = 3'd5,
    UP2  = 3'd6
  } state_t;

  // Check codes driven to the pads. Each one is distinct, so a stuck pin shows up.
  localparam logic [3:0] CHK_OFF = 4'h0;
  localparam logic [3:0] CHK_A   = 4'h9;
  localparam logic [3:0] CHK_AB  = 4'h5;

  // Status encodings: {domain B up, domain A up}.
  localparam logic [1:0] ST_OFF = 2'b00;
  localparam logic [1:0] ST_A   = 2'b01;
  localparam logic [1:0] ST_AB  = 2'b11;

endpackage

// File: rtl/por_sync.sv
// Multi-flop synchroniser for one asynchronous power-good flag.
// Every stage clears to 0, so after reset the flag reads as "power not good".
module por_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage samples the asynchronous input.
        always_ff @(posedge clock or negedge resetb) begin
          if (!resetb) sync_reg[gi] <= 1'b0;
          else         sync_reg[gi] <= d;
        end
      end else begin : g_rest
        // Later stages give a metastable value time to resolve.
        always_ff @(posedge clock or negedge resetb) begin
          if (!resetb) sync_reg[gi] <= 1'b0;
          else         sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/por_sequencer.sv
// Staged release of user-domain resets from two power-good detectors.
// Each flag is synchronised and debounced. Each domain is then held for a fixed
// delay before its reset is released. A brown-out reasserts the affected resets
// and sets a sticky fault.
module por_sequencer
  import por_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RELEASE_DELAY   = 8,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       por1_i,
  input  logic       por2_i,
  input  logic       fault_clr,
  output logic       rst_a_n,
  output logic       rst_b_n,
  output logic [1:0] status,
  output logic [3:0] checkbits,
  output logic       fault_o
);

  logic             por1_s;
  logic             por2_s;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             deb_done, dly_done;
  logic             counting;
  logic             fault_set, fault_next;
  logic             rst_a_next, rst_b_next;
  logic [1:0]       status_next;
  logic [3:0]       checkbits_next;

  por_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_por1 (
    .clock  (clock),
    .resetb (resetb),
    .d      (por1_i),
    .q      (por1_s)
  );

  por_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_por2 (
    .clock  (clock),
    .resetb (resetb),
    .d      (por2_i),
    .q      (por2_s)
  );

  assign deb_done = (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign dly_done = (cnt_reg == CNT_W'(RELEASE_DELAY - 1));

  // State, counter and all outputs are registered together, so every output
  // changes on the same edge as the state and cannot glitch.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_reg <= OFF;
      cnt_reg   <= '0;
      rst_a_n   <= 1'b0;
      rst_b_n   <= 1'b0;
      status    <= ST_OFF;
      checkbits <= CHK_OFF;
      fault_o   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rst_a_n   <= rst_a_next;
      rst_b_n   <= rst_b_next;
      status    <= status_next;
      checkbits <= checkbits_next;
      fault_o   <= fault_next;
    end
  end

  // Next-state logic. Loss of por1 always wins and drops straight to OFF.
  always_comb begin
    state_next = state_reg;
    if (state_reg != OFF && !por1_s) begin
      state_next = OFF;
    end else begin
      case (state_reg)
        OFF:     if (por1_s) state_next = DEB1;
        DEB1:    if (deb_done) state_next = DLY1;
        DLY1:    if (dly_done) state_next = UP1;
        UP1:     if (por2_s) state_next = DEB2;
        DEB2:    if (!por2_s) state_next = UP1;
                 else if (deb_done) state_next = DLY2;
        DLY2:    if (!por2_s) state_next = UP1;
                 else if (dly_done) state_next = UP2;
        UP2:     if (!por2_s) state_next = UP1;
        default: state_next = OFF;
      endcase
    end
  end

  // Counter restarts on every state change and runs only in the debounce and delay states.
  always_comb begin
    counting = (state_reg == DEB1) || (state_reg == DLY1) ||
               (state_reg == DEB2) || (state_reg == DLY2);
    cnt_next = cnt_reg;
    if (state_next != state_reg) cnt_next = '0;
    else if (counting)           cnt_next = cnt_reg + 1'b1;
  end

  // Output decode from the next state. The sticky fault sets on any loss of a
  // domain that was already up, and a set beats a coincident clear.
  always_comb begin
    rst_a_next     = 1'b0;
    rst_b_next     = 1'b0;
    status_next    = ST_OFF;
    checkbits_next = CHK_OFF;
    case (state_next)
      UP1, DEB2, DLY2: begin
        rst_a_next     = 1'b1;
        status_next    = ST_A;
        checkbits_next = CHK_A;
      end
      UP2: begin
        rst_a_next     = 1'b1;
        rst_b_next     = 1'b1;
        status_next    = ST_AB;
        checkbits_next = CHK_AB;
      end
      default: ;
    endcase

    fault_set = ((state_reg == UP1 || state_reg == DEB2 || state_reg == DLY2 ||
                  state_reg == UP2) && state_next == OFF) ||
                (state_reg == UP2 && state_next == UP1);
    fault_next = fault_o;
    if (fault_set)      fault_next = 1'b1;
    else if (fault_clr) fault_next = 1'b0;
  end

endmodule

// File: tb/tb_por_sequencer.sv
// Directed bench for por_sequencer. Inputs are driven and outputs sampled on the
// falling edge. Expected values come from the edge counts worked out by hand.
module tb_por_sequencer;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       por1_i = 1'b0;
  logic       por2_i = 1'b0;
  logic       fault_clr = 1'b0;
  logic       rst_a_n, rst_b_n, fault_o;
  logic [1:0] status;
  logic [3:0] checkbits;

  int n_vec  = 0;
  int n_miss = 0;

  por_sequencer dut (
    .clock     (clock),
    .resetb    (resetb),
    .por1_i    (por1_i),
    .por2_i    (por2_i),
    .fault_clr (fault_clr),
    .rst_a_n   (rst_a_n),
    .rst_b_n   (rst_b_n),
    .status    (status),
    .checkbits (checkbits),
    .fault_o   (fault_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h t=%0t", tag, got, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ra, input logic rb,
                            input logic [1:0] st, input logic [3:0] cb, input logic f);
    check({tag, ".rst_a_n"},   8'(rst_a_n),   8'(ra));
    check({tag, ".rst_b_n"},   8'(rst_b_n),   8'(rb));
    check({tag, ".status"},    8'(status),    8'(st));
    check({tag, ".checkbits"}, 8'(checkbits), 8'(cb));
    check({tag, ".fault_o"},   8'(fault_o),   8'(f));
  endtask

  // Advance n rising edges and stop on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    // Reset state
    step(3);
    check_outs("reset", 1'b0, 1'b0, 2'b00, 4'h0, 1'b0);
    resetb = 1'b1;
    step(2);
    check_outs("idle", 1'b0, 1'b0, 2'b00, 4'h0, 1'b0);

    // Nominal: domain A is released on edge 27 after por1 is sampled
    por1_i = 1'b1;
    step(26);
    check_outs("nom_a_e26", 1'b0, 1'b0, 2'b00, 4'h0, 1'b0);
    step(1);
    check_outs("nom_a_e27", 1'b1, 1'b0, 2'b01, 4'h9, 1'b0);
    step(173);
    por2_i = 1'b1;
    step(26);
    check_outs("nom_b_e26", 1'b1, 1'b0, 2'b01, 4'h9, 1'b0);
    step(1);
    check_outs("nom_b_e27", 1'b1, 1'b1, 2'b11, 4'h5, 1'b0);

    // Domain B brown-out: UP2 -> UP1 after the sync delay, fault set
    por2_i = 1'b0;
    step(2);
    check("bob_e2.rst_b_n", 8'(rst_b_n), 8'd1);
    step(1);
    check_outs("bob_e3", 1'b1, 1'b0, 2'b01, 4'h9, 1'b1);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("bob_clr.fault_o", 8'(fault_o), 8'd0);

    // Return to UP2, then domain A brown-out with clear on the set edge
    por2_i = 1'b1;
    step(27);
    check("reup.status", 8'(status), 8'h3);
    por1_i = 1'b0;
    step(2);
    check("boa_e2.status", 8'(status), 8'h3);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check_outs("boa_e3", 1'b0, 1'b0, 2'b00, 4'h0, 1'b1);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    check("boa_clr.fault_o", 8'(fault_o), 8'd0);

    // Glitch on por1 shorter than the debounce window, with por2 already high
    por1_i = 1'b1;
    step(10);
    check("glitch_hi.rst_a_n", 8'(rst_a_n), 8'd0);
    por1_i = 1'b0;
    step(10);
    check_outs("glitch_lo", 1'b0, 1'b0, 2'b00, 4'h0, 1'b0);

    // Steady por1 with early por2: A at edge 27, B 25 edges after UP1 entry
    por1_i = 1'b1;
    step(26);
    check("early_e26.rst_a_n", 8'(rst_a_n), 8'd0);
    step(1);
    check_outs("early_up1", 1'b1, 1'b0, 2'b01, 4'h9, 1'b0);
    step(24);
    check("early_b24.rst_b_n", 8'(rst_b_n), 8'd0);
    step(1);
    check_outs("early_b25", 1'b1, 1'b1, 2'b11, 4'h5, 1'b0);

    // Async reset in DLY2: outputs clear with no clock edge
    por2_i = 1'b0;
    step(3);
    check("pre_rst.fault_o", 8'(fault_o), 8'd1);
    por2_i = 1'b1;
    step(22);
    check("dly2.status", 8'(status), 8'h1);
    check("dly2.rst_b_n", 8'(rst_b_n), 8'd0);
    #2 resetb = 1'b0;
    #1 check_outs("async_rst", 1'b0, 1'b0, 2'b00, 4'h0, 1'b0);
    @(negedge clock);
    resetb = 1'b1;
    step(26);
    check("restart_e26.rst_a_n", 8'(rst_a_n), 8'd0);
    step(1);
    check_outs("restart_e27", 1'b1, 1'b0, 2'b01, 4'h9, 1'b0);
    step(25);
    check_outs("restart_b", 1'b1, 1'b1, 2'b11, 4'h5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
